// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared types for the bit-serial subtractor.
//   state_t : controller state encoding (IDLE, RUN, DONE)
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/subtractor_1bit.sv
// ---------------------------------------------------------------------------
// subtractor_1bit
// Purely combinational 1-bit full subtractor: computes a - b - borrow_in.
// Ports:
//   a          : minuend bit
//   b          : subtrahend bit
//   borrow_in  : borrow from the less significant bit
//   diff       : difference bit
//   borrow_out : borrow into the next more significant bit
// ---------------------------------------------------------------------------
module subtractor_1bit (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   always_comb begin
      diff       = a ^ b ^ borrow_in;
      // Borrow when a=0,b=1, or when a==b and a borrow is already pending.
      borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

      assert (!$isunknown(a))
         else $error("subtractor_1bit: input a is not 0/1");
      assert (!$isunknown(b))
         else $error("subtractor_1bit: input b is not 0/1");
      assert (!$isunknown(borrow_in))
         else $error("subtractor_1bit: input borrow_in is not 0/1");
   end

endmodule : subtractor_1bit

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
// Bit-serial two's-complement subtractor: minuend - subtrahend, one bit per
// clock, LSB first, through a single full-subtractor cell and a registered
// borrow. Results are registered and held until the next completion.
// Ports:
//   clk        : system clock, rising edge
//   n_rst      : asynchronous active-low reset
//   start      : begin an operation (honoured in IDLE or DONE only)
//   minuend    : operand A, captured on the accepting edge
//   subtrahend : operand B, captured on the accepting edge
//   busy       : high while an operation is shifting (RUN)
//   done       : one-cycle pulse, results newly updated (DONE)
//   difference : A - B modulo 2^WIDTH
//   borrow_out : 1 iff A < B unsigned
//   overflow   : signed overflow of A - B
// ---------------------------------------------------------------------------
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [WIDTH-1:0] minuend,
   input  logic [WIDTH-1:0] subtrahend,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] difference,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state_reg;
   state_t             state_next;

   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   // Holds the WIDTH-1 result bits produced so far; the final bit joins them
   // on the completing edge, so the register never needs a discarded LSB.
   logic [WIDTH-2:0]   r_sr;
   logic               borrow_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic               a_msb_reg;
   logic               b_msb_reg;

   logic               cell_d;
   logic               cell_bout;
   logic               load;
   logic               last_bit;
   logic [WIDTH-1:0]   r_shift;

   subtractor_1bit u_cell (
      .a          (a_sr[0]),
      .b          (b_sr[0]),
      .borrow_in  (borrow_reg),
      .diff       (cell_d),
      .borrow_out (cell_bout)
   );

   assign load     = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_CNT);
   assign r_shift  = {cell_d, r_sr};

   assign busy = (state_reg == RUN);
   assign done = (state_reg == DONE);

   // ------------------------------------------------------------------
   // Controller
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (last_bit) begin
               state_next = DONE;
            end
         end
         DONE: begin
            // Back-to-back operation skips IDLE entirely.
            state_next = start ? RUN : IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         borrow_reg <= 1'b0;
         cnt_reg    <= '0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         difference <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else if (load) begin
         a_sr       <= minuend;
         b_sr       <= subtrahend;
         borrow_reg <= 1'b0;
         cnt_reg    <= '0;
         // Sign bits are kept aside because the operand registers are
         // shifted away by the time overflow is evaluated.
         a_msb_reg  <= minuend[WIDTH-1];
         b_msb_reg  <= subtrahend[WIDTH-1];
      end else if (state_reg == RUN) begin
         a_sr       <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr       <= {1'b0, b_sr[WIDTH-1:1]};
         r_sr       <= r_shift[WIDTH-1:1];
         borrow_reg <= cell_bout;
         cnt_reg    <= cnt_reg + CNT_W'(1);
         if (last_bit) begin
            difference <= r_shift;
            borrow_out <= cell_bout;
            overflow   <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
         end
      end
   end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk;
   logic             n_rst;
   logic             start;
   logic [WIDTH-1:0] minuend;
   logic [WIDTH-1:0] subtrahend;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] difference;
   logic             borrow_out;
   logic             overflow;

   int checks   = 0;
   int failures = 0;
   logic [WIDTH-1:0] prev_diff;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] exp_diff;
      logic             exp_bout;
      logic             exp_ovf;
   } vec_t;

   vec_t vecs[9];

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .minuend    (minuend),
      .subtrahend (subtrahend),
      .busy       (busy),
      .done       (done),
      .difference (difference),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Entered and left at a falling edge. Runs one operation to completion.
   task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
      int n;
      int busy_cnt;
      start      = 1'b1;
      minuend    = a;
      subtrahend = b;
      @(negedge clk);
      start      = 1'b0;
      minuend    = a ^ 8'h5A;   // must not affect the captured operands
      subtrahend = ~b;
      check("hold_in_run", difference, prev_diff);
      n = 0;
      busy_cnt = 0;
      while (!done && n < 40) begin
         if (busy) busy_cnt++;
         @(negedge clk);
         n++;
      end
      check("latency", n, WIDTH);
      check("busy_cycles", busy_cnt, WIDTH);
      check("busy_at_done", busy, 0);
      check("difference", difference, ed);
      check("borrow_out", borrow_out, eb);
      check("overflow", overflow, eo);
      $display("op A=%0d B=%0d -> diff=%0h bout=%0b ovf=%0b latency=%0d",
               a, b, difference, borrow_out, overflow, n);
      @(negedge clk);
      check("done_pulse_len", done, 0);
      check("hold_in_idle", difference, ed);
      prev_diff = ed;
   endtask

   initial begin
      int dcount;
      int cyc;
      int extra_busy;
      int d1;
      int d2;

      vecs[0] = '{8'd100,  8'd37,   8'd63,   1'b0, 1'b0};
      vecs[1] = '{8'd5,    8'd9,    8'hFC,   1'b1, 1'b0};
      vecs[2] = '{8'd0,    8'd0,    8'h00,   1'b0, 1'b0};
      vecs[3] = '{8'h80,   8'h01,   8'h7F,   1'b0, 1'b1};
      vecs[4] = '{8'h7F,   8'hFF,   8'h80,   1'b1, 1'b1};
      vecs[5] = '{8'hFF,   8'hFF,   8'h00,   1'b0, 1'b0};
      vecs[6] = '{8'h00,   8'h01,   8'hFF,   1'b1, 1'b0};
      vecs[7] = '{8'h80,   8'h7F,   8'h01,   1'b0, 1'b1};
      vecs[8] = '{8'h01,   8'h80,   8'h81,   1'b1, 1'b1};

      n_rst      = 1'b0;
      start      = 1'b0;
      minuend    = '0;
      subtrahend = '0;
      prev_diff  = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_difference", difference, 0);
      check("rst_borrow_out", borrow_out, 0);
      check("rst_overflow", overflow, 0);
      n_rst = 1'b1;
      @(negedge clk);

      // Table-driven operations
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);
      end

      // start toggled and operands changed throughout RUN
      start      = 1'b1;
      minuend    = 8'd50;
      subtrahend = 8'd20;
      @(negedge clk);
      dcount = 0;
      extra_busy = 0;
      for (int c = 0; c < 30; c++) begin
         if (done) begin
            dcount++;
            check("toggle_difference", difference, 30);
            start = 1'b0;
         end else if (busy) begin
            if (dcount > 0) extra_busy++;
            start      = ~start;
            minuend    = 8'(c * 37);
            subtrahend = 8'(c * 11 + 3);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      check("toggle_done_count", dcount, 1);
      check("toggle_no_extra_op", extra_busy, 0);
      $display("op toggle A=50 B=20 -> diff=%0d done_pulses=%0d", difference, dcount);

      // start held high: back-to-back operations
      start      = 1'b1;
      minuend    = 8'd10;
      subtrahend = 8'd3;
      d1 = -1;
      d2 = -1;
      cyc = 0;
      while (cyc < 30 && d2 < 0) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            if (d1 < 0) begin
               d1 = cyc;
               check("b2b_diff1", difference, 7);
               check("b2b_bout1", borrow_out, 0);
               minuend    = 8'd3;
               subtrahend = 8'd10;
            end else begin
               d2 = cyc;
               check("b2b_diff2", difference, 8'hF9);
               check("b2b_bout2", borrow_out, 1);
               check("b2b_ovf2", overflow, 0);
               start = 1'b0;
            end
         end else if (d1 > 0 && cyc == d1 + 1) begin
            check("b2b_busy_after_done", busy, 1);
         end
      end
      check("b2b_done_cycle1", d1, 9);
      check("b2b_done_cycle2", d2, 18);
      $display("op back-to-back done at cycles %0d and %0d", d1, d2);
      @(negedge clk);
      check("b2b_idle", busy, 0);
      prev_diff = 8'hF9;

      // Asynchronous reset in the middle of RUN
      start      = 1'b1;
      minuend    = 8'd200;
      subtrahend = 8'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 n_rst = 1'b0;
      #1;
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_difference", difference, 0);
      check("arst_borrow_out", borrow_out, 0);
      check("arst_overflow", overflow, 0);
      @(negedge clk);
      n_rst = 1'b1;
      dcount = 0;
      extra_busy = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (done) dcount++;
         if (busy) extra_busy++;
      end
      check("arst_no_done", dcount, 0);
      check("arst_no_busy", extra_busy, 0);
      $display("op reset mid-run -> outputs cleared, idle afterwards");
      prev_diff = '0;
      run_op(8'd200, 8'd1, 8'hC7, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_subtractor
